spi_controller: RTL and testbench

- SPI initiator that drives the 3-wire register-write interface (SCLK, COPI, nCS) used by the onboarding chip's SPI peripheral.
- Serialises one 16-bit frame per request: R/W bit, 7-bit address, 8-bit data, MSB first, SPI mode 0.
- Used as an on-chip or FPGA bring-up master and as the bench-side driver model for the peripheral.
- Also samples CIPO so a read-capable responder can return data.

---
 rtl/spi_controller.sv | 97 +++++++++
 tb/tb_spi_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator that sends one {rw, addr[6:0], wdata[7:0]} frame MSB first per request
// Ports:
//   clk, rst_n         system clock, synchronous active-low reset
//   start, rw, addr,   request strobe (sampled only in IDLE) and frame fields
//   wdata
//   cipo               serial data from the peripheral, sampled on each SCLK rise
//   busy, done         busy from acceptance until the done cycle; done is a one-cycle completion pulse
//   rdata              last 8 CIPO bits of the most recent frame
//   sclk, copi, ncs    SPI pins (sclk idles low, ncs active low)
module spi_controller #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       cipo,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;
  state_t state, state_d;
  logic [15:0] tx_shift;
  logic [7:0] rx_shift;
  logic [4:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic phase_end;
  assign phase_end = div_cnt == DW'(CLK_DIV - 1);
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = start ? SETUP : IDLE;
      SETUP:    state_d = phase_end ? SHIFT_HI : SETUP;
      SHIFT_HI: state_d = phase_end ? SHIFT_LO : SHIFT_HI;
      SHIFT_LO: state_d = !phase_end ? SHIFT_LO : (bit_cnt == 5'd16 ? HOLD : SHIFT_HI);
      HOLD:     state_d = phase_end ? GAP : HOLD;
      GAP:      state_d = phase_end ? IDLE : GAP;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      sclk     <= 1'b0;
      copi     <= 1'b0;
      ncs      <= 1'b1;
    end else begin
      div_cnt <= (state == IDLE || state_d != state) ? '0 : div_cnt + 1'b1;
      done    <= 1'b0;
      if (state == IDLE && start) begin
        tx_shift <= {rw, addr, wdata};
        copi     <= rw;
        bit_cnt  <= '0;
        busy     <= 1'b1;
        ncs      <= 1'b0;
      end
      // every entry into SHIFT_HI is an SCLK rise: sample CIPO there
      if (state_d == SHIFT_HI && state != SHIFT_HI) begin
        sclk     <= 1'b1;
        rx_shift <= {rx_shift[6:0], cipo};
      end
      // falling edge: advance to the next tx bit unless the 16th bit was just sent
      if (state == SHIFT_HI && phase_end) begin
        sclk    <= 1'b0;
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt != 5'd15) begin
          tx_shift <= {tx_shift[14:0], tx_shift[15]};
          copi     <= tx_shift[14];
        end
      end
      if (state == HOLD && phase_end) ncs <= 1'b1;
      if (state == GAP && phase_end) begin
        done  <= 1'b1;
        busy  <= 1'b0;
        rdata <= rx_shift;
        copi  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed, table-driven bench for spi_controller with CLK_DIV=4
module tb_spi_controller;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic cipo = 1'b0;
  logic busy, done, sclk, copi, ncs;
  logic [7:0] rdata;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  spi_controller #(.CLK_DIV(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .cipo(cipo), .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .copi(copi), .ncs(ncs)
  );
  typedef struct {
    logic rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [15:0] pat;
    logic [15:0] exp_copi;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  // Accept one frame (start on the edge before sample c=1), flip the input fields after
  // acceptance, drive cipo from pat MSB first, optionally re-pulse start at samples pa/pb.
  task automatic run_frame(input vec_t v, input int pa, input int pb, output logic [15:0] bits,
                           output int rises, output int ncs_low, output int done_at,
                           output int done_cnt, output logic busy_at, output logic [7:0] rd);
    logic prev;
    prev = 1'b0;
    bits = '0;
    rises = 0;
    ncs_low = 0;
    done_at = 0;
    done_cnt = 0;
    busy_at = 1'b1;
    rd = '0;
    rw = v.rw;
    addr = v.addr;
    wdata = v.wdata;
    cipo = v.pat[15];
    start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == pa || c == pb);
      rw = ~v.rw;
      addr = ~v.addr;
      wdata = ~v.wdata;
      if (sclk && !prev) begin
        bits = {bits[14:0], copi};
        rises++;
      end
      prev = sclk;
      if (!ncs) ncs_low++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = c;
          busy_at = busy;
          rd = rdata;
        end
      end
      if (rises < 16) cipo = v.pat[15 - rises];
      if (done_at != 0 && c >= done_at + 2) break;
    end
    start = 1'b0;
  endtask
  initial begin
    logic [15:0] bits;
    int rises, ncs_low, done_at, done_cnt, dn, r, run, quiet, mid_done, mid_low;
    logic busy_at, prev, expect_busy;
    logic [7:0] rd;
    vecs[0] = '{1'b0, 7'h01, 8'h00, 16'hFF3C, 16'h0100, 8'h3C};
    vecs[1] = '{1'b1, 7'h00, 8'hF0, 16'h0000, 16'h80F0, 8'h00};
    vecs[2] = '{1'b1, 7'h7F, 8'h5A, 16'h00C3, 16'hFF5A, 8'hC3};
    vecs[3] = '{1'b0, 7'h2A, 8'hA5, 16'hAAAA, 16'h2AA5, 8'hAA};
    repeat (3) @(negedge clk);
    chk("rst_ncs", ncs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_copi", copi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i], 0, 0, bits, rises, ncs_low, done_at, done_cnt, busy_at, rd);
      chk($sformatf("v%0d_copi", i), bits, vecs[i].exp_copi);
      chk($sformatf("v%0d_rises", i), rises, 16);
      chk($sformatf("v%0d_ncs_low", i), ncs_low, 34 * H);
      chk($sformatf("v%0d_done_at", i), done_at, 35 * H + 1);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_busy_at_done", i), busy_at, 0);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    // start pulses mid-frame must be ignored
    run_frame(vecs[1], 10, 50, bits, rises, ncs_low, done_at, done_cnt, busy_at, rd);
    chk("pulse_rises", rises, 16);
    chk("pulse_done_cnt", done_cnt, 1);
    chk("pulse_done_at", done_at, 35 * H + 1);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (!ncs || busy || done) quiet++;
    end
    chk("pulse_no_extra_frame", quiet, 0);
    // start held high: three back-to-back frames, each accepted in its done cycle
    dn = 0;
    r = 0;
    run = 0;
    prev = 1'b0;
    expect_busy = 1'b0;
    rw = 1'b1;
    addr = 7'h05;
    wdata = 8'h11;
    cipo = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 450 && dn < 3; c++) begin
      @(negedge clk);
      if (expect_busy) begin
        chk($sformatf("b2b_accept%0d", dn), busy, 1);
        expect_busy = 1'b0;
      end
      if (sclk && !prev) r++;
      prev = sclk;
      if (ncs) run++;
      else begin
        if (run > 0 && dn > 0) chk($sformatf("b2b_gap%0d_ge_h", dn), run >= H, 1);
        run = 0;
      end
      if (done) begin
        dn++;
        if (dn < 3) expect_busy = 1'b1;
        else start = 1'b0;
      end
    end
    chk("b2b_dones", dn, 3);
    chk("b2b_rises", r, 48);
    @(negedge clk);
    chk("b2b_stop", busy, 0);
    // reset asserted for one cycle at SCLK rise #7
    r = 0;
    prev = 1'b0;
    rw = 1'b1;
    addr = 7'h03;
    wdata = 8'h77;
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sclk && !prev) r++;
      prev = sclk;
      if (r == 7 && sclk) begin
        rst_n = 1'b0;
        break;
      end
    end
    chk("mid_reached_rise7", r, 7);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_ncs", ncs, 1);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    mid_done = 0;
    mid_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) mid_done++;
      if (!ncs) mid_low++;
    end
    chk("mid_no_done", mid_done, 0);
    chk("mid_ncs_stays_high", mid_low, 0);
    run_frame(vecs[0], 0, 0, bits, rises, ncs_low, done_at, done_cnt, busy_at, rd);
    chk("post_rst_copi", bits, vecs[0].exp_copi);
    chk("post_rst_rises", rises, 16);
    chk("post_rst_done_at", done_at, 35 * H + 1);
    chk("post_rst_rdata", rd, vecs[0].exp_rdata);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
